// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, command opcodes and parser states shared by the framebuffer blocks
package fb_pkg;
   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_BYTES  = FB_WIDTH * FB_HEIGHT / 8;
   localparam int ADDR_W    = 14;
   localparam logic [7:0] CMD_WRITE = 8'hA5;
   localparam logic [7:0] CMD_FILL  = 8'h55;
   localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_BYTES - 1);
   typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, FILL_VAL, FILL} state_t;
   function automatic logic [ADDR_W-1:0] fb_next(input logic [ADDR_W-1:0] a);
      return a == FB_LAST ? '0 : a + ADDR_W'(1);
   endfunction
endpackage

// File: rtl/serial_fb_writer.sv
// serial_fb_writer: parses UART bytes into framebuffer block writes or a whole-frame fill
module serial_fb_writer
   import fb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cmd_done,
   output logic              err,
   output logic              overrun
);
   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n, cnt, cnt_n, wr_addr_n;
   logic [5:0]        hi, hi_n;
   logic [7:0]        wr_data_n;
   logic              wr_en_n, done_n, err_n, ovr_n;
   // next state and next registered outputs; wr_data doubles as the fill value during FILL
   always_comb begin
      state_n   = state;
      addr_n    = addr;
      cnt_n     = cnt;
      hi_n      = hi;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      done_n    = 1'b0;
      err_n     = 1'b0;
      ovr_n     = 1'b0;
      case (state)
         IDLE: if (rx_valid) begin
            state_n = rx_data == CMD_WRITE ? ADDR_HI : rx_data == CMD_FILL ? FILL_VAL : IDLE;
            err_n   = rx_data != CMD_WRITE && rx_data != CMD_FILL;
         end
         ADDR_HI, LEN_HI: if (rx_valid) begin
            hi_n    = rx_data[5:0];
            state_n = state == ADDR_HI ? ADDR_LO : LEN_LO;
         end
         ADDR_LO: if (rx_valid) begin
            err_n   = {hi, rx_data} > FB_LAST;
            addr_n  = {hi, rx_data};
            state_n = err_n ? IDLE : LEN_HI;
         end
         LEN_LO: if (rx_valid) begin
            done_n  = {hi, rx_data} == '0;
            cnt_n   = {hi, rx_data};
            state_n = done_n ? IDLE : DATA;
         end
         DATA: if (rx_valid) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr;
            wr_data_n = rx_data;
            addr_n    = fb_next(addr);
            cnt_n     = cnt - ADDR_W'(1);
            done_n    = cnt == ADDR_W'(1);
            state_n   = done_n ? IDLE : DATA;
         end
         FILL_VAL: if (rx_valid) begin
            wr_en_n   = 1'b1;
            wr_addr_n = '0;
            wr_data_n = rx_data;
            addr_n    = ADDR_W'(1);
            state_n   = FILL;
         end
         FILL: begin
            ovr_n = rx_valid;
            if (wr_addr == FB_LAST) state_n = IDLE;
            else begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr;
               addr_n    = fb_next(addr);
               done_n    = addr == FB_LAST;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   // state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= '0;
         cnt      <= '0;
         hi       <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cmd_done <= 1'b0;
         err      <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         cnt      <= cnt_n;
         hi       <= hi_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         cmd_done <= done_n;
         err      <= err_n;
         overrun  <= ovr_n;
      end
   end
endmodule

// File: tb/tb_serial_fb_writer.sv
// tb_serial_fb_writer: directed vector table plus fill and reset sequences for serial_fb_writer
module tb_serial_fb_writer;
   import fb_pkg::*;
   logic              clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
   logic [7:0]        rx_data = '0, wr_data;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en, cmd_done, err, overrun;
   int                n_cmp = 0, n_bad = 0;
   typedef struct {
      logic              v;
      logic [7:0]        d;
      logic              we;
      logic [ADDR_W-1:0] a;
      logic [7:0]        wd;
      logic              done, er, ovr;
   } vec_t;
   vec_t tbl[$];

   serial_fb_writer dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_done(cmd_done), .err(err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic we, input int a,
                      input logic [7:0] wd, input logic done, input logic er);
      vec_t r;
      r.v = v; r.d = d; r.we = we; r.a = ADDR_W'(a); r.wd = wd; r.done = done; r.er = er; r.ovr = 1'b0;
      tbl.push_back(r);
   endtask

   function automatic logic [63:0] pack(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                                        input logic done, input logic er, input logic ovr);
      return {37'd0, we, we ? a : '0, we ? wd : 8'h00, done, er, ovr};
   endfunction

   task automatic fill_run(input string name, input logic [7:0] val, input int inject);
      int bad = 0;
      step(1'b1, CMD_FILL);
      step(1'b1, val);
      for (int k = 0; k < FB_BYTES; k++) begin
         if (!(wr_en && wr_addr == ADDR_W'(k) && wr_data == val && cmd_done == (k == FB_BYTES - 1)
               && overrun == (k == inject + 1) && !err)) bad++;
         @(negedge clk);
         rx_valid = k == inject || k == FB_BYTES - 1;
         rx_data  = k == inject ? 8'h12 : CMD_WRITE;
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
      check({name, " bad cycles"}, 64'(bad), 64'd0);
      check({name, " tail drop"}, pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun), pack(0, 0, 0, 0, 0, 1));
      step(1'b1, 8'h00);
      check({name, " idle after"}, pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun), pack(0, 0, 0, 0, 1, 0));
   endtask

   initial begin
      add(1, 8'hA5, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h10, 0, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h03, 0, 0, 0, 0, 0);
      add(1, 8'h11, 1, 16, 8'h11, 0, 0); add(1, 8'h22, 1, 17, 8'h22, 0, 0); add(1, 8'h33, 1, 18, 8'h33, 1, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0);
      add(1, 8'hA5, 0, 0, 0, 0, 0); add(1, 8'hE5, 0, 0, 0, 0, 0); add(1, 8'h7F, 0, 0, 0, 0, 0);
      add(1, 8'hC0, 0, 0, 0, 0, 0); add(1, 8'h02, 0, 0, 0, 0, 0);
      add(1, 8'hAA, 1, 9599, 8'hAA, 0, 0); add(1, 8'hBB, 1, 0, 8'hBB, 1, 0);
      add(1, 8'hA5, 0, 0, 0, 0, 0); add(1, 8'h25, 0, 0, 0, 0, 0); add(1, 8'h80, 0, 0, 0, 0, 1);
      add(1, 8'hA5, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h01, 0, 0, 0, 0, 0); add(1, 8'h7E, 1, 0, 8'h7E, 1, 0);
      add(1, 8'hA5, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h00, 0, 0, 0, 0, 1 == 0); add(1, 8'h00, 0, 0, 0, 0, 1);
      add(1, 8'h12, 0, 0, 0, 0, 1);
      tbl[29].done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", {wr_en, wr_addr, wr_data, cmd_done, err, overrun}, '0);
      @(negedge clk);
      reset = 1'b0;
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d);
         check($sformatf("vec %0d", i), pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun),
               pack(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].done, tbl[i].er, tbl[i].ovr));
      end
      fill_run("fill F0", 8'hF0, 100);
      step(1'b1, 8'hA5); step(1'b1, 8'h00); step(1'b1, 8'h20); step(1'b1, 8'h00); step(1'b1, 8'h05);
      step(1'b1, 8'h01);
      check("pre-reset w0", pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun), pack(1, 32, 8'h01, 0, 0, 0));
      step(1'b1, 8'h02);
      check("pre-reset w1", pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun), pack(1, 33, 8'h02, 0, 0, 0));
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h03;
      @(posedge clk);
      #1;
      check("mid-data reset", {wr_en, wr_addr, wr_data, cmd_done, err, overrun}, '0);
      @(negedge clk);
      reset    = 1'b0;
      rx_valid = 1'b0;
      step(1'b1, 8'h03);
      check("idle after reset", pack(wr_en, wr_addr, wr_data, cmd_done, err, overrun), pack(0, 0, 0, 0, 1, 0));
      fill_run("fill 00", 8'h00, -5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
